// File: rtl/serializer.sv
// rtl/serializer.sv - parallel-to-serial converter, MSB-first with valid/ready toward the sink
module serializer #(
  parameter int DATA_W = 16,
  parameter int MOD_W  = $clog2(DATA_W)
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [MOD_W-1:0]  data_mod_i,
  input  logic              data_val_i,
  output logic              busy_o,
  output logic              ser_data_o,
  output logic              ser_data_val_o,
  output logic              ser_last_o,
  input  logic              ser_ready_i
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [MOD_W:0] FULL_CNT = (MOD_W+1)'(DATA_W);
  localparam logic [MOD_W:0] ONE_CNT  = (MOD_W+1)'(1);
  localparam logic [MOD_W:0] TWO_CNT  = (MOD_W+1)'(2);

  state_t            state_q, state_n;
  logic [DATA_W-1:0] shreg_q, shreg_n;
  logic [MOD_W:0]    cnt_q, cnt_n;
  logic [MOD_W:0]    load_cnt;
  logic              busy_n, data_n, val_n, last_n;
  logic              xfer;

  // Zero selects a full word; oversize counts (non-power-of-2 widths) clamp to DATA_W.
  always_comb begin
    load_cnt = {1'b0, data_mod_i};
    if (data_mod_i == '0 || {1'b0, data_mod_i} > FULL_CNT)
      load_cnt = FULL_CNT;
  end

  assign xfer = ser_data_val_o & ser_ready_i;

  always_comb begin
    state_n = state_q;
    shreg_n = shreg_q;
    cnt_n   = cnt_q;
    busy_n  = busy_o;
    data_n  = ser_data_o;
    val_n   = ser_data_val_o;
    last_n  = ser_last_o;
    unique case (state_q)
      IDLE: begin
        if (data_val_i) begin
          state_n = SHIFT;
          shreg_n = data_i;
          cnt_n   = load_cnt;
          busy_n  = 1'b1;
          val_n   = 1'b1;
          data_n  = data_i[DATA_W-1];
          last_n  = (load_cnt == ONE_CNT);
        end
      end
      SHIFT: begin
        if (xfer) begin
          if (ser_last_o) begin
            state_n = IDLE;
            shreg_n = '0;
            cnt_n   = '0;
            busy_n  = 1'b0;
            val_n   = 1'b0;
            data_n  = 1'b0;
            last_n  = 1'b0;
          end else begin
            shreg_n = {shreg_q[DATA_W-2:0], 1'b0};
            cnt_n   = cnt_q - ONE_CNT;
            data_n  = shreg_q[DATA_W-2];
            last_n  = (cnt_q == TWO_CNT);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q        <= IDLE;
      shreg_q        <= '0;
      cnt_q          <= '0;
      busy_o         <= 1'b0;
      ser_data_o     <= 1'b0;
      ser_data_val_o <= 1'b0;
      ser_last_o     <= 1'b0;
    end else begin
      state_q        <= state_n;
      shreg_q        <= shreg_n;
      cnt_q          <= cnt_n;
      busy_o         <= busy_n;
      ser_data_o     <= data_n;
      ser_data_val_o <= val_n;
      ser_last_o     <= last_n;
    end
  end

endmodule

// File: tb/tb_serializer.sv
// tb/tb_serializer.sv - directed self-checking bench for serializer
module tb_serializer;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  data_mod = '0;
  logic        data_val = 1'b0;
  logic        busy, ser_data, ser_val, ser_last;
  logic        ser_ready = 1'b1;

  int checks = 0;
  int failures = 0;

  serializer dut (
    .clk_i         (clk),
    .arst_n_i      (arst_n),
    .data_i        (data),
    .data_mod_i    (data_mod),
    .data_val_i    (data_val),
    .busy_o        (busy),
    .ser_data_o    (ser_data),
    .ser_data_val_o(ser_val),
    .ser_last_o    (ser_last),
    .ser_ready_i   (ser_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_val"}, ser_val, 0);
    chk({tag, "_last"}, ser_last, 0);
  endtask

  // First bit is already presented; drain n bits and compare with the top n bits of w.
  task automatic collect(input logic [15:0] w, input int n, input bit rnd);
    logic [15:0] got;
    logic [2:0]  prev;
    int          cnt;
    int          guard;
    bit          rdy;
    got = '0;
    cnt = 0;
    guard = 0;
    while (cnt < n && guard < 400) begin
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      ser_ready = rdy;
      chk("bit_val", ser_val, 1);
      chk("bit_busy", busy, 1);
      chk("bit_last", ser_last, (cnt == n - 1));
      prev = {ser_data, ser_val, ser_last};
      if (rdy) begin
        got = {got[14:0], ser_data};
        cnt++;
      end
      step();
      if (!rdy) chk("hold", {ser_data, ser_val, ser_last}, prev);
      guard++;
    end
    ser_ready = 1'b1;
    chk("timeout", (guard < 400), 1);
    chk("word", got, w >> (16 - n));
  endtask

  task automatic send(input logic [15:0] w, input logic [3:0] m, input bit rnd);
    int n;
    n = (m == 0) ? 16 : int'(m);
    data = w;
    data_mod = m;
    data_val = 1'b1;
    step();
    data_val = 1'b0;
    chk("first_busy", busy, 1);
    chk("first_bit", ser_data, w[15]);
    collect(w, n, rnd);
    check_idle("end");
  endtask

  initial begin
    logic [15:0] w;
    // Reset state
    #2;
    check_idle("rst");
    chk("rst_data", ser_data, 0);
    step();
    arst_n = 1'b1;
    step();
    check_idle("post_rst");

    // Full word, ready held high; then a 3-bit partial word and a 1-bit word
    send(16'hA5C3, 4'd0, 1'b0);
    send(16'hF000, 4'd3, 1'b0);
    send(16'h8000, 4'd1, 1'b0);

    // Backpressure
    send(16'h8001, 4'd0, 1'b1);

    // data_val held high: second word only accepted in the idle cycle
    data = 16'h1234;
    data_mod = 4'd0;
    data_val = 1'b1;
    step();
    data = 16'hFFFF;
    chk("hold_first", ser_data, 0);
    collect(16'h1234, 16, 1'b0);
    check_idle("gap");
    step();
    data_val = 1'b0;
    chk("second_busy", busy, 1);
    chk("second_first", ser_data, 1);
    collect(16'hFFFF, 16, 1'b0);
    check_idle("second_end");

    // Async reset after 5 bits
    data = 16'hBEEF;
    data_val = 1'b1;
    step();
    data_val = 1'b0;
    repeat (5) step();
    chk("pre_rst_val", ser_val, 1);
    #2 arst_n = 1'b0;
    #1;
    check_idle("async_rst");
    chk("async_rst_data", ser_data, 0);
    #3 arst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_idle("after_rst");
    end
    send(16'h0F0F, 4'd0, 1'b0);

    // Random words, random ready
    for (int i = 0; i < 200; i++) begin
      w = 16'($urandom);
      send(w, 4'd0, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serializer.md
Name: serializer

Overview:
- Parallel-to-serial converter: the transmit end of the bit-serial link consumed by the team's deserializer.
- Captures a DATA_W-bit word plus a bit count, then emits the bits MSB-first, one per accepted cycle, with a valid/ready handshake toward the sink.
- Sits between a word-oriented producer and the serial lane. An upstream stall window lets the producer pace words.

Parameters:
- DATA_W, 16, width of the parallel word (>= 2).
- MOD_W, $clog2(DATA_W), width of the bit-count input.

Ports:
- clk_i  input  1  clock.
- arst_n_i  input  1  reset, asynchronous, active-low.
- data_i  input  DATA_W  parallel word; bit DATA_W-1 is sent first.
- data_mod_i  input  MOD_W  number of bits to send, counted from the MSB; 0 means DATA_W.
- data_val_i  input  1  data_i/data_mod_i valid; captured only when busy_o=0.
- busy_o  output  1  word in flight; data_val_i ignored while high.
- ser_data_o  output  1  current serial bit.
- ser_data_val_o  output  1  ser_data_o valid.
- ser_last_o  output  1  current bit is the last of the word.
- ser_ready_i  input  1  sink accepts the bit this cycle.

Behaviour:
- Reset (arst_n_i=0, async): state=IDLE; busy_o=0, ser_data_o=0, ser_data_val_o=0, ser_last_o=0; shift register and counter cleared. A reset mid-word discards the word; no further bits are emitted.
- All outputs are registered.
- FSM IDLE:
  - If data_val_i=1: load shift reg <= data_i and remaining count <= (data_mod_i==0 ? DATA_W : data_mod_i), then go to SHIFT.
  - Next cycle: busy_o=1, ser_data_val_o=1, ser_data_o=data_i[DATA_W-1], ser_last_o=(count==1). Latency from accept to first bit is 1 cycle.
- FSM SHIFT:
  - A transfer happens when ser_data_val_o & ser_ready_i.
  - On a transfer that is not the last: shift left by 1, decrement count. The next MSB appears on the following cycle.
  - With ser_ready_i=0: ser_data_o, ser_data_val_o and ser_last_o hold unchanged. No bit is lost or repeated.
  - On a transfer with ser_last_o=1: go to IDLE. Next cycle busy_o=0, ser_data_val_o=0, ser_last_o=0.
- Word boundary:
  - The earliest new accept is the first IDLE cycle, so back-to-back words show exactly 1 idle cycle between the last bit and the next first bit when ser_ready_i is held at 1.
  - data_val_i asserted while busy_o=1 is ignored. It is not queued.
- Count rules:
  - Count register is MOD_W+1 bits wide to hold DATA_W.
  - Bits below the sent count are never emitted.
  - A data_mod_i value greater than DATA_W (possible only for non-power-of-2 DATA_W) is clamped to DATA_W.
- ser_last_o is high only together with ser_data_val_o.
- Throughput with ser_ready_i=1: N bits in N cycles, plus 1 accept cycle and 1 idle cycle.

Test Plan:
- Reset, then data_i=16'hA5C3, data_mod_i=0, data_val_i pulse, ser_ready_i=1 -> starting the cycle after accept, 16 consecutive ser_data_val_o=1 cycles carrying 1010_0101_1100_0011 MSB-first; ser_last_o=1 only on the 16th; busy_o falls the cycle after.
- data_i=16'hF000, data_mod_i=3 -> exactly 3 bits 1,1,1 emitted, ser_last_o on the 3rd; remaining bits never appear.
- data_i=16'h8001, data_mod_i=0, ser_ready_i randomly 50% -> sequence reconstructed on transfer cycles equals 16'h8001; outputs stable during ready=0 cycles.
- Word 16'h1234 sent, data_val_i held high with 16'hFFFF throughout -> only 16'h1234 is sent while busy; 16'hFFFF is accepted in the first IDLE cycle and sent after exactly 1 idle cycle.
- arst_n_i pulsed low asynchronously after 5 bits of 16'hBEEF -> all outputs 0 immediately; after release no bits until a new data_val_i; the new word 16'h0F0F is sent intact.
- Loopback: serializer feeding the deserializer (deser data_val_i = ser_data_val_o & ser_ready_i), 200 random 16-bit words, data_mod_i=0, random ready -> every deser_data_o equals the word sent.
